lcd_de_receiver: RTL and testbench

- Sink side of the DE-mode RGB565 parallel LCD interface that the panel driver produces.
- Recovers pixel coordinates, frame and line boundaries, and measured active resolution from LCD_DE alone.
- Flags timing errors and reports lock. Used for loopback self-test of the LCD driver and as the front end for a capture path.

---
 rtl/lcd_de_receiver_if.sv | 40 ++++
 rtl/lcd_de_receiver.sv | 236 +++++++++++++++++++++++
 tb/tb_lcd_de_receiver.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/lcd_de_receiver_if.sv
// Bus bundle for the DE-mode RGB565 LCD sink: panel-side inputs, recovered pixel stream and status.
// The master modport is the LCD driver / capture consumer side, the slave modport is lcd_de_receiver.
interface lcd_de_receiver_if #(
  parameter int H_MAX = 1024,
  parameter int V_MAX = 512
);
  localparam int XW = $clog2(H_MAX);
  localparam int YW = $clog2(V_MAX);

  logic          LCD_DE;
  logic [4:0]    LCD_R;
  logic [5:0]    LCD_G;
  logic [4:0]    LCD_B;
  logic          err_clr;
  logic          pix_valid;
  logic [15:0]   pix_data;
  logic [XW-1:0] pix_x;
  logic [YW-1:0] pix_y;
  logic          sof;
  logic          eol;
  logic          frame_done;
  logic [XW:0]   meas_w;
  logic [YW:0]   meas_h;
  logic          locked;
  logic          err_width;
  logic          err_overflow;
  logic [15:0]   frame_crc;

  modport master (
    output LCD_DE, LCD_R, LCD_G, LCD_B, err_clr,
    input  pix_valid, pix_data, pix_x, pix_y, sof, eol, frame_done,
    input  meas_w, meas_h, locked, err_width, err_overflow, frame_crc
  );

  modport slave (
    input  LCD_DE, LCD_R, LCD_G, LCD_B, err_clr,
    output pix_valid, pix_data, pix_x, pix_y, sof, eol, frame_done,
    output meas_w, meas_h, locked, err_width, err_overflow, frame_crc
  );
endinterface

// File: rtl/lcd_de_receiver.sv
// DE-only LCD timing recovery: pixel coordinates, frame/line markers, measured size, lock and errors.
// Optional per-frame CRC-16/CCITT-FALSE over pix_data is enabled with `define LCD_RX_CRC_EN.
module lcd_de_receiver #(
  parameter int H_MAX       = 1024,
  parameter int V_MAX       = 512,
  parameter int VBLANK_MIN  = 256,
  parameter int LOCK_FRAMES = 2
) (
  input logic              PixelClk,
  input logic              nRST,
  lcd_de_receiver_if.slave bus
);
  localparam int XW  = $clog2(H_MAX);
  localparam int YW  = $clog2(V_MAX);
  localparam int XW1 = XW + 1;
  localparam int YW1 = YW + 1;
  localparam int CW  = $clog2(VBLANK_MIN) + 1;
  localparam int LW  = $clog2(LOCK_FRAMES) + 1;

  localparam logic [XW-1:0] X_LAST = XW'(H_MAX - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(V_MAX - 1);
  localparam logic [CW-1:0] C_LAST = CW'(VBLANK_MIN - 1);
  localparam logic [CW-1:0] C_MAX  = CW'(VBLANK_MIN);
  localparam logic [LW-1:0] L_MAX  = LW'(LOCK_FRAMES);

  localparam logic [1:0] SEEK   = 2'd0;
  localparam logic [1:0] VBLANK = 2'd1;
  localparam logic [1:0] LINE   = 2'd2;
  localparam logic [1:0] HBLANK = 2'd3;

  logic          de_s1_r;
  logic [15:0]   rgb_s1_r;
  logic [1:0]    state_r, state_nxt_s, idle_nxt_s;
  logic [CW-1:0] de_low_cnt_r;
  logic [XW-1:0] x_r, cur_x_s;
  logic [YW-1:0] y_r, cur_y_s;
  logic [XW:0]   width_r, line_len_s, meas_w_r;
  logic [YW:0]   meas_h_r, meas_h_nxt_s;
  logic [LW-1:0] lock_cnt_r, lock_cnt_nxt_s;
  logic          frame_bad_r, locked_r, err_width_r, err_overflow_r;
  logic          emit_s, sof_s, eol_s, ovf_s, done_s, width_err_s;
  logic          pix_valid_r, sof_r, eol_r, frame_done_r;
  logic [15:0]   pix_data_r;
  logic [XW-1:0] pix_x_r;
  logic [YW-1:0] pix_y_r;

  // Per-state decision on the stage-1 sample: emit a pixel, detect overflow or frame end
  always_comb begin
    idle_nxt_s = state_r;
    emit_s     = 1'b0;
    sof_s      = 1'b0;
    ovf_s      = 1'b0;
    done_s     = 1'b0;
    cur_x_s    = x_r;
    cur_y_s    = y_r;
    case (state_r)
      SEEK: begin
        if (!de_s1_r && (de_low_cnt_r >= C_LAST)) idle_nxt_s = VBLANK;
        else idle_nxt_s = SEEK;
      end
      VBLANK: begin
        if (de_s1_r) begin
          emit_s  = 1'b1;
          sof_s   = 1'b1;
          cur_x_s = {XW{1'b0}};
          cur_y_s = {YW{1'b0}};
        end else begin
          idle_nxt_s = VBLANK;
        end
      end
      LINE: begin
        if (de_s1_r) begin
          if (x_r == X_LAST) begin
            ovf_s = 1'b1;
          end else begin
            emit_s  = 1'b1;
            cur_x_s = x_r + XW'(1);
          end
        end else begin
          idle_nxt_s = HBLANK;
        end
      end
      HBLANK: begin
        if (de_s1_r) begin
          if (y_r == Y_LAST) begin
            ovf_s = 1'b1;
          end else begin
            emit_s  = 1'b1;
            cur_x_s = {XW{1'b0}};
            cur_y_s = y_r + YW'(1);
          end
        end else if (de_low_cnt_r == C_LAST) begin
          done_s     = 1'b1;
          idle_nxt_s = VBLANK;
        end else begin
          idle_nxt_s = HBLANK;
        end
      end
      default: idle_nxt_s = SEEK;
    endcase
  end

  // Line-end checks, final next state and lock bookkeeping
  always_comb begin
    eol_s        = emit_s & ~bus.LCD_DE;
    line_len_s   = {1'b0, cur_x_s} + XW1'(1);
    width_err_s  = eol_s && (cur_y_s != {YW{1'b0}}) && (line_len_s != width_r);
    meas_h_nxt_s = {1'b0, y_r} + YW1'(1);
    if (ovf_s) state_nxt_s = SEEK;
    else if (emit_s) state_nxt_s = eol_s ? HBLANK : LINE;
    else state_nxt_s = idle_nxt_s;
    // A clean frame with a new geometry starts a fresh run of one rather than dropping to zero
    if (ovf_s) begin
      lock_cnt_nxt_s = {LW{1'b0}};
    end else if (done_s) begin
      if (frame_bad_r) lock_cnt_nxt_s = {LW{1'b0}};
      else if ((width_r == meas_w_r) && (meas_h_nxt_s == meas_h_r))
        lock_cnt_nxt_s = (lock_cnt_r == L_MAX) ? L_MAX : lock_cnt_r + LW'(1);
      else lock_cnt_nxt_s = LW'(1);
    end else begin
      lock_cnt_nxt_s = lock_cnt_r;
    end
  end

  // Input stage, blank counter, FSM, position and frame measurement state
  always_ff @(posedge PixelClk or negedge nRST) begin
    if (!nRST) begin
      de_s1_r      <= 1'b0;
      rgb_s1_r     <= 16'h0000;
      de_low_cnt_r <= {CW{1'b0}};
      state_r      <= SEEK;
      x_r          <= {XW{1'b0}};
      y_r          <= {YW{1'b0}};
      width_r      <= {XW1{1'b0}};
      frame_bad_r  <= 1'b0;
      meas_w_r     <= {XW1{1'b0}};
      meas_h_r     <= {YW1{1'b0}};
      lock_cnt_r   <= {LW{1'b0}};
      locked_r     <= 1'b0;
    end else begin
      de_s1_r      <= bus.LCD_DE;
      rgb_s1_r     <= {bus.LCD_R, bus.LCD_G, bus.LCD_B};
      de_low_cnt_r <= de_s1_r ? {CW{1'b0}} :
                      ((de_low_cnt_r == C_MAX) ? C_MAX : de_low_cnt_r + CW'(1));
      state_r      <= state_nxt_s;
      if (emit_s) begin
        x_r <= cur_x_s;
        y_r <= cur_y_s;
      end
      if (eol_s && (cur_y_s == {YW{1'b0}})) width_r <= line_len_s;
      frame_bad_r  <= (sof_s ? 1'b0 : frame_bad_r) | width_err_s;
      if (done_s) begin
        meas_w_r <= width_r;
        meas_h_r <= meas_h_nxt_s;
      end
      lock_cnt_r   <= lock_cnt_nxt_s;
      locked_r     <= (lock_cnt_nxt_s == L_MAX);
    end
  end

  // Sticky error flags; a new event outranks a simultaneous clear
  always_ff @(posedge PixelClk or negedge nRST) begin
    if (!nRST) begin
      err_width_r    <= 1'b0;
      err_overflow_r <= 1'b0;
    end else begin
      err_width_r    <= width_err_s ? 1'b1 : (bus.err_clr ? 1'b0 : err_width_r);
      err_overflow_r <= ovf_s       ? 1'b1 : (bus.err_clr ? 1'b0 : err_overflow_r);
    end
  end

  // Output stage: second register on the pixel path
  always_ff @(posedge PixelClk or negedge nRST) begin
    if (!nRST) begin
      pix_valid_r  <= 1'b0;
      pix_data_r   <= 16'h0000;
      pix_x_r      <= {XW{1'b0}};
      pix_y_r      <= {YW{1'b0}};
      sof_r        <= 1'b0;
      eol_r        <= 1'b0;
      frame_done_r <= 1'b0;
    end else begin
      pix_valid_r  <= emit_s;
      sof_r        <= sof_s;
      eol_r        <= eol_s;
      frame_done_r <= done_s;
      if (emit_s) begin
        pix_data_r <= rgb_s1_r;
        pix_x_r    <= cur_x_s;
        pix_y_r    <= cur_y_s;
      end
    end
  end

`ifdef LCD_RX_CRC_EN
  function automatic logic [15:0] crc16_word(input logic [15:0] crc, input logic [15:0] data);
    logic [15:0] c;
    c = crc;
    for (int i = 15; i >= 0; i--) begin
      if (c[15] ^ data[i]) c = {c[14:0], 1'b0} ^ 16'h1021;
      else c = {c[14:0], 1'b0};
    end
    return c;
  endfunction

  logic [15:0] crc_r, frame_crc_r;

  // Running CRC restarted on the first pixel of a frame, published with frame_done
  always_ff @(posedge PixelClk or negedge nRST) begin
    if (!nRST) begin
      crc_r       <= 16'hFFFF;
      frame_crc_r <= 16'h0000;
    end else begin
      if (emit_s) crc_r <= crc16_word(sof_s ? 16'hFFFF : crc_r, rgb_s1_r);
      if (done_s) frame_crc_r <= crc_r;
    end
  end

  assign bus.frame_crc = frame_crc_r;
`else
  assign bus.frame_crc = 16'h0000;
`endif

  assign bus.pix_valid    = pix_valid_r;
  assign bus.pix_data     = pix_data_r;
  assign bus.pix_x        = pix_x_r;
  assign bus.pix_y        = pix_y_r;
  assign bus.sof          = sof_r;
  assign bus.eol          = eol_r;
  assign bus.frame_done   = frame_done_r;
  assign bus.meas_w       = meas_w_r;
  assign bus.meas_h       = meas_h_r;
  assign bus.locked       = locked_r;
  assign bus.err_width    = err_width_r;
  assign bus.err_overflow = err_overflow_r;
endmodule

// File: tb/tb_lcd_de_receiver.sv
// Directed bench for lcd_de_receiver: per-frame vector table plus hand-written corner sequences.
module tb_lcd_de_receiver;
  logic clk;
  logic rst_n;

  lcd_de_receiver_if bus ();

  lcd_de_receiver dut (
    .PixelClk(clk),
    .nRST    (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int w;
    int h;
    int short_y;
    int short_len;
    bit clr;
    int exp_w;
    int exp_h;
    bit exp_locked;
    bit exp_errw;
    int exp_pix;
  } frame_vec_t;

  frame_vec_t tbl[9];

  int checks = 0;
  int failures = 0;
  int pix_cnt = 0, sof_cnt = 0, eol_cnt = 0, done_cnt = 0, last_x = 0;
  int cap_w, cap_h, cap_pix, cap_sof, cap_eol;
  bit cap_locked, cap_errw;
  logic [15:0] cap_crc;
  bit chk_data = 1'b1;
  bit crc_mode = 1'b0;
  int d0;

  logic [78:0] all_outs;
  assign all_outs = {bus.pix_valid, bus.pix_data, bus.pix_x, bus.pix_y, bus.sof, bus.eol,
                     bus.frame_done, bus.meas_w, bus.meas_h, bus.locked, bus.err_width,
                     bus.err_overflow, bus.frame_crc};

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [15:0] pat(input int x, input int y);
    if (crc_mode) return 16'(y * 4 + x);
    else return {y[5:0], x[9:0]};
  endfunction

  function automatic logic [15:0] crc_model(input int n);
    logic [15:0] c;
    c = 16'hFFFF;
    for (int w = 0; w < n; w++) begin
      c = c ^ 16'(w);
      for (int b = 0; b < 16; b++) c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
    end
    return c;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic de, input logic [15:0] d);
    bus.LCD_DE = de;
    bus.LCD_R  = d[15:11];
    bus.LCD_G  = d[10:5];
    bus.LCD_B  = d[4:0];
    step();
  endtask

  task automatic send_lines(input int w, input int y0, input int y1, input int hb, input int vb,
                            input int sy, input int slen);
    int len;
    int gap;
    for (int y = y0; y < y1; y++) begin
      len = (y == sy) ? slen : w;
      gap = (y == y1 - 1) ? vb : hb;
      for (int x = 0; x < len; x++) drive(1'b1, pat(x, y));
      for (int k = 0; k < gap; k++) drive(1'b0, 16'h0000);
    end
  endtask

  task automatic pulse_clr();
    bus.err_clr = 1'b1;
    step();
    bus.err_clr = 1'b0;
  endtask

  task automatic frame_check(input string tag, input int w, input int h, input bit lk);
    d0 = done_cnt;
    send_lines(w, 0, h, 5, 300, -1, 0);
    check({tag, "_done"}, done_cnt, d0 + 1);
    check({tag, "_meas_w"}, cap_w, w);
    check({tag, "_locked"}, cap_locked, lk);
  endtask

  // Output monitor, sampled on the falling edge
  always @(negedge clk) begin
    if (bus.pix_valid) begin
      pix_cnt++;
      last_x = int'(bus.pix_x);
      if (bus.sof) begin
        sof_cnt++;
        check("sof_position", {bus.pix_x, bus.pix_y}, 0);
      end
      if (bus.eol) eol_cnt++;
      if (chk_data) check("pix_data", bus.pix_data, pat(int'(bus.pix_x), int'(bus.pix_y)));
    end
    if (bus.frame_done) begin
      done_cnt++;
      cap_w      = int'(bus.meas_w);
      cap_h      = int'(bus.meas_h);
      cap_locked = bus.locked;
      cap_errw   = bus.err_width;
      cap_crc    = bus.frame_crc;
      cap_pix    = pix_cnt;
      cap_sof    = sof_cnt;
      cap_eol    = eol_cnt;
      pix_cnt    = 0;
      sof_cnt    = 0;
      eol_cnt    = 0;
    end
  end

  initial begin
    //          w   h  sy slen clr  ew  eh lk ew  pix
    tbl[0] = '{16, 8, -1,  0, 1'b0, 16, 8, 1'b0, 1'b0, 128};
    tbl[1] = '{16, 8, -1,  0, 1'b0, 16, 8, 1'b1, 1'b0, 128};
    tbl[2] = '{16, 8,  5, 15, 1'b0, 16, 8, 1'b0, 1'b1, 127};
    tbl[3] = '{16, 8, -1,  0, 1'b0, 16, 8, 1'b0, 1'b1, 128};
    tbl[4] = '{16, 8, -1,  0, 1'b1, 16, 8, 1'b1, 1'b1, 128};
    tbl[5] = '{12, 6, -1,  0, 1'b0, 12, 6, 1'b0, 1'b0,  72};
    tbl[6] = '{12, 6, -1,  0, 1'b0, 12, 6, 1'b1, 1'b0,  72};
    tbl[7] = '{ 1, 3, -1,  0, 1'b0,  1, 3, 1'b0, 1'b0,   3};
    tbl[8] = '{ 1, 3, -1,  0, 1'b0,  1, 3, 1'b1, 1'b0,   3};

    rst_n       = 1'b0;
    bus.LCD_DE  = 1'b0;
    bus.LCD_R   = 5'd0;
    bus.LCD_G   = 6'd0;
    bus.LCD_B   = 5'd0;
    bus.err_clr = 1'b0;
    repeat (3) step();
    check("reset_outputs_zero", |all_outs, 0);
    rst_n = 1'b1;

    // Stream joins at line 100 of a 16x120 frame: nothing may be emitted before vblank
    send_lines(16, 100, 120, 5, 300, -1, 0);
    check("partial_no_pix", pix_cnt, 0);
    check("partial_no_done", done_cnt, 0);

    // Single-pixel frame: 2-cycle latency, sof and eol together
    chk_data = 1'b0;
    bus.LCD_DE = 1'b1;
    {bus.LCD_R, bus.LCD_G, bus.LCD_B} = 16'hA5C3;
    step();
    check("lat_not_yet_valid", bus.pix_valid, 0);
    bus.LCD_DE = 1'b0;
    step();
    check("lat_valid", bus.pix_valid, 1);
    check("lat_sof", bus.sof, 1);
    check("lat_eol", bus.eol, 1);
    check("lat_xy", {bus.pix_x, bus.pix_y}, 0);
    check("lat_data", bus.pix_data, 16'hA5C3);
    step();
    check("lat_valid_drop", bus.pix_valid, 0);
    repeat (300) drive(1'b0, 16'h0000);
    check("px1_done", done_cnt, 1);
    check("px1_meas_w", cap_w, 1);
    check("px1_meas_h", cap_h, 1);
    chk_data = 1'b1;

    for (int i = 0; i < 9; i++) begin
      d0 = done_cnt;
      send_lines(tbl[i].w, 0, tbl[i].h, 5, 300, tbl[i].short_y, tbl[i].short_len);
      check($sformatf("vec%0d_done", i), done_cnt, d0 + 1);
      check($sformatf("vec%0d_meas_w", i), cap_w, tbl[i].exp_w);
      check($sformatf("vec%0d_meas_h", i), cap_h, tbl[i].exp_h);
      check($sformatf("vec%0d_locked", i), cap_locked, tbl[i].exp_locked);
      check($sformatf("vec%0d_err_width", i), cap_errw, tbl[i].exp_errw);
      check($sformatf("vec%0d_pix", i), cap_pix, tbl[i].exp_pix);
      check($sformatf("vec%0d_sof", i), cap_sof, 1);
      check($sformatf("vec%0d_eol", i), cap_eol, tbl[i].h);
      if (tbl[i].clr) begin
        pulse_clr();
        check($sformatf("vec%0d_err_width_clr", i), bus.err_width, 0);
      end
    end

    // DE held high for 1100 cycles: overflow after x=1023, back to seek
    d0 = done_cnt;
    pix_cnt = 0;
    for (int x = 0; x < 1100; x++) drive(1'b1, pat(x, 0));
    check("xovf_flag", bus.err_overflow, 1);
    check("xovf_locked", bus.locked, 0);
    check("xovf_pix", pix_cnt, 1024);
    check("xovf_last_x", last_x, 1023);
    repeat (300) drive(1'b0, 16'h0000);
    check("xovf_no_done", done_cnt, d0);
    check("xovf_quiet", pix_cnt, 1024);
    pix_cnt = 0;
    frame_check("xrec1", 16, 8, 1'b0);
    frame_check("xrec2", 16, 8, 1'b1);
    pulse_clr();
    check("xovf_clr", bus.err_overflow, 0);

    // 513 lines: the 513th line start overflows y
    d0 = done_cnt;
    pix_cnt = 0;
    send_lines(2, 0, 513, 3, 300, -1, 0);
    check("yovf_flag", bus.err_overflow, 1);
    check("yovf_locked", bus.locked, 0);
    check("yovf_no_done", done_cnt, d0);
    check("yovf_pix", pix_cnt, 1024);

    // Reset in the middle of line 10
    send_lines(16, 0, 10, 5, 5, -1, 0);
    for (int x = 0; x < 5; x++) drive(1'b1, pat(x, 10));
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_outputs_zero", |all_outs, 0);
    step();
    #3;
    rst_n = 1'b1;
    pix_cnt = 0;
    d0 = done_cnt;
    for (int x = 5; x < 16; x++) drive(1'b1, pat(x, 10));
    for (int k = 0; k < 5; k++) drive(1'b0, 16'h0000);
    send_lines(16, 11, 20, 5, 300, -1, 0);
    check("midrst_no_pix", pix_cnt, 0);
    check("midrst_no_done", done_cnt, d0);
    frame_check("rrec1", 16, 8, 1'b0);
    frame_check("rrec2", 16, 8, 1'b1);

    // 4x2 frame of words 0..7 for the frame CRC
    crc_mode = 1'b1;
    d0 = done_cnt;
    send_lines(4, 0, 2, 5, 300, -1, 0);
    crc_mode = 1'b0;
    check("crc_done", done_cnt, d0 + 1);
    check("crc_pix", cap_pix, 8);
`ifdef LCD_RX_CRC_EN
    check("frame_crc", cap_crc, crc_model(8));
`else
    check("frame_crc_zero", cap_crc, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
